// File: rtl/edge_hyst_det_pkg.sv
// Shared constants for the gradient edge path: default image width and the
// default strong/weak thresholds used by the Sobel stage and display logic.
package edge_hyst_det_pkg;

  localparam int          IMG_W_DEFAULT         = 640;
  localparam logic [15:0] GRADIENT_THRESHOLD_HI = 16'd100;
  localparam logic [15:0] GRADIENT_THRESHOLD_LO = 16'd50;

  // Row index width; only y==0 matters to the datapath, the rest saturates.
  localparam int Y_W = 16;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_WEAK   = 2'd1,
    CLS_STRONG = 2'd2
  } grad_class_e;

endpackage

// File: rtl/edge_line_buf.sv
// One-row store of final edge decisions: combinational reads at idx (above)
// and idx+1 (above-right), registered write at idx.
module edge_line_buf #(
  parameter int IMG_W = 640,
  parameter int X_W   = 10
) (
  input  logic           clk,
  input  logic           wr_en,
  input  logic [X_W-1:0] idx,
  input  logic           wr_bit,
  output logic           above,
  output logic           above_right
);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);

  logic           mem [IMG_W];
  logic [X_W-1:0] idx_next;

  assign idx_next    = idx + X_W'(1);
  assign above       = mem[idx];
  // idx+1 has not been rewritten yet this row, so it still holds the prior row.
  assign above_right = (idx == X_LAST) ? 1'b0 : mem[idx_next];

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wr_bit;
  end

endmodule

// File: rtl/edge_hyst_det.sv
// Streaming edge classifier: single threshold or causal hysteresis against
// already-decided neighbours, with a per-frame saturating edge count.
module edge_hyst_det
  import edge_hyst_det_pkg::*;
#(
  parameter int GRAD_W = 16,
  parameter int IMG_W  = IMG_W_DEFAULT,
  parameter int X_W    = 10,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              sof,
  input  logic [GRAD_W-1:0] gradient,
  input  logic [GRAD_W-1:0] thresh_hi,
  input  logic [GRAD_W-1:0] thresh_lo,
  input  logic              hyst_en,
  output logic              out_valid,
  output logic              pixel_edge,
  output logic              pixel_strong,
  output logic [CNT_W-1:0]  frame_edges,
  output logic              frame_done
);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic inc);
    if (inc && (c != '1)) return c + CNT_W'(1);
    return c;
  endfunction

  function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] y);
    if (y == '1) return y;
    return y + Y_W'(1);
  endfunction

  // With thresh_lo >= thresh_hi any g > lo is also > hi, so weak cannot occur.
  function automatic grad_class_e classify(input logic [GRAD_W-1:0] g,
                                           input logic [GRAD_W-1:0] hi,
                                           input logic [GRAD_W-1:0] lo);
    if (g > hi) return CLS_STRONG;
    if (g > lo) return CLS_WEAK;
    return CLS_NONE;
  endfunction

  logic              armed;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic              left_q;
  logic              al_q;
  logic [CNT_W-1:0]  run_cnt;

  logic              accept;
  logic [X_W-1:0]    x_p0;
  logic [Y_W-1:0]    y_p0;
  logic              has_left;
  logic              not_top;
  logic              a_raw;
  logic              ar_raw;
  logic              nbr_p0;
  grad_class_e       cls_p0;
  logic              strong_p0;
  logic              edge_p0;

  // ---- stage p0: position, classification and neighbour decision ----
  assign accept    = in_valid && (armed || sof);
  assign x_p0      = sof ? '0 : x_q;
  assign y_p0      = sof ? '0 : y_q;
  assign has_left  = (x_p0 != '0);
  assign not_top   = (y_p0 != '0);
  assign cls_p0    = classify(gradient, thresh_hi, thresh_lo);
  assign strong_p0 = (cls_p0 == CLS_STRONG);
  assign nbr_p0    = (has_left && left_q) ||
                     (has_left && not_top && al_q) ||
                     (not_top && a_raw) ||
                     (not_top && ar_raw);
  assign edge_p0   = strong_p0 || (hyst_en && (cls_p0 == CLS_WEAK) && nbr_p0);

  edge_line_buf #(
    .IMG_W (IMG_W),
    .X_W   (X_W)
  ) u_line_buf (
    .clk         (clk),
    .wr_en       (accept),
    .idx         (x_p0),
    .wr_bit      (edge_p0),
    .above       (a_raw),
    .above_right (ar_raw)
  );

  // The raw above value becomes the next pixel's above-left, since the
  // buffer location at x-1 has already been overwritten by the current row.
  always_ff @(posedge clk) begin
    if (accept) begin
      left_q <= edge_p0;
      al_q   <= a_raw;
    end
  end

  // ---- stage p1: registered outputs, position and frame counting ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      armed        <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      run_cnt      <= '0;
      out_valid    <= 1'b0;
      pixel_edge   <= 1'b0;
      pixel_strong <= 1'b0;
      frame_edges  <= '0;
      frame_done   <= 1'b0;
    end else begin
      out_valid  <= accept;
      frame_done <= 1'b0;
      if (accept) begin
        armed        <= 1'b1;
        pixel_edge   <= edge_p0;
        pixel_strong <= strong_p0;
        if (x_p0 == X_LAST) begin
          x_q <= '0;
          y_q <= sat_inc_y(y_p0);
        end else begin
          x_q <= x_p0 + X_W'(1);
          y_q <= y_p0;
        end
        if (sof) begin
          if (armed) begin
            frame_edges <= run_cnt;
            frame_done  <= 1'b1;
          end
          run_cnt <= {{(CNT_W-1){1'b0}}, edge_p0};
        end else begin
          run_cnt <= sat_inc(run_cnt, edge_p0);
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_hyst_det.sv
// Directed bench for edge_hyst_det with a 4-pixel line and a 2-bit counter.
module tb_edge_hyst_det;
  import edge_hyst_det_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        sof;
  logic [15:0] gradient;
  logic [15:0] thresh_hi;
  logic [15:0] thresh_lo;
  logic        hyst_en;
  logic        out_valid;
  logic        pixel_edge;
  logic        pixel_strong;
  logic [1:0]  frame_edges;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  edge_hyst_det #(
    .GRAD_W (16),
    .IMG_W  (4),
    .X_W    (2),
    .CNT_W  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .sof          (sof),
    .gradient     (gradient),
    .thresh_hi    (thresh_hi),
    .thresh_lo    (thresh_lo),
    .hyst_en      (hyst_en),
    .out_valid    (out_valid),
    .pixel_edge   (pixel_edge),
    .pixel_strong (pixel_strong),
    .frame_edges  (frame_edges),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic px(input logic [15:0] g, input logic s);
    in_valid = 1'b1;
    sof      = s;
    gradient = g;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sof      = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    sof      = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, pixel_edge, pixel_strong, frame_edges, frame_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset outputs got %b%b%b %b %b exp all zero",
               out_valid, pixel_edge, pixel_strong, frame_edges, frame_done);
    end
  endtask

  task automatic test_pre_arm();
    hyst_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      px(16'd200, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL pre_arm[%0d] out_valid got %b exp 0", i, out_valid);
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] g [4];
    logic        e [4];
    g = '{16'd100, 16'd101, 16'd0, 16'd65535};
    e = '{1'b0, 1'b1, 1'b0, 1'b1};
    hyst_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      px(g[i], i == 0);
      checks++;
      if ({out_valid, pixel_edge, pixel_strong} !== {1'b1, e[i], e[i]}) begin
        errors++;
        $display("FAIL single[%0d] valid/edge/strong got %b%b%b exp 1%b%b",
                 i, out_valid, pixel_edge, pixel_strong, e[i], e[i]);
      end
    end
    idle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle out_valid got %b exp 0", out_valid);
    end
  endtask

  task automatic test_hysteresis();
    logic [15:0] g [8];
    logic        e [8];
    g = '{16'd200, 16'd60, 16'd60, 16'd10, 16'd10, 16'd10, 16'd10, 16'd60};
    e = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    hyst_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      px(g[i], i == 0);
      checks++;
      if ({out_valid, pixel_edge} !== {1'b1, e[i]}) begin
        errors++;
        $display("FAIL hyst[%0d] valid/edge got %b%b exp 1%b", i, out_valid, pixel_edge, e[i]);
      end
    end
  endtask

  task automatic test_gaps();
    hyst_en = 1'b1;
    px(16'd200, 1'b1);
    idle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap out_valid got %b exp 0", out_valid);
    end
    px(16'd10, 1'b0);
    px(16'd10, 1'b0);
    px(16'd60, 1'b0);
    checks++;
    if ({out_valid, pixel_edge} !== 2'b10) begin
      errors++;
      $display("FAIL gap_row0_x3 valid/edge got %b%b exp 10", out_valid, pixel_edge);
    end
    px(16'd60, 1'b0);
    checks++;
    if ({out_valid, pixel_edge} !== 2'b11) begin
      errors++;
      $display("FAIL gap_row1_x0 valid/edge got %b%b exp 11", out_valid, pixel_edge);
    end
  endtask

  task automatic test_masking();
    logic [15:0] g [4];
    logic        e [4];
    hyst_en = 1'b1;
    for (int i = 0; i < 4; i++) px(16'd200, i == 0);
    for (int i = 0; i < 4; i++) begin
      px(16'd60, i == 0);
      checks++;
      if ({out_valid, pixel_edge} !== 2'b10) begin
        errors++;
        $display("FAIL mask_row0[%0d] valid/edge got %b%b exp 10", i, out_valid, pixel_edge);
      end
    end
    g = '{16'd10, 16'd200, 16'd10, 16'd10};
    e = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      px(g[i], i == 0);
      checks++;
      if (pixel_edge !== e[i]) begin
        errors++;
        $display("FAIL ar_row0[%0d] edge got %b exp %b", i, pixel_edge, e[i]);
      end
    end
    px(16'd60, 1'b0);
    checks++;
    if ({out_valid, pixel_edge} !== 2'b11) begin
      errors++;
      $display("FAIL ar_tap edge got %b%b exp 11", out_valid, pixel_edge);
    end
  endtask

  task automatic test_frame_count();
    logic [15:0] g1 [8];
    logic [15:0] g2 [7];
    int          pulses;
    g1 = '{16'd200, 16'd0, 16'd200, 16'd0, 16'd0, 16'd0, 16'd200, 16'd0};
    g2 = '{16'd200, 16'd200, 16'd200, 16'd200, 16'd200, 16'd0, 16'd0};
    hyst_en = 1'b0;
    pulses  = 0;
    px(g1[0], 1'b1);
    for (int i = 1; i < 8; i++) begin
      px(g1[i], 1'b0);
      if (frame_done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL frame_mid_pulses got %0d exp 0", pulses);
    end
    px(16'd0, 1'b1);
    checks++;
    if ({out_valid, frame_done, frame_edges} !== 4'b1111) begin
      errors++;
      $display("FAIL frame3 valid/done/edges got %b%b %0d exp 11 3",
               out_valid, frame_done, frame_edges);
    end
    for (int i = 0; i < 7; i++) px(g2[i], 1'b0);
    checks++;
    if ({frame_done, frame_edges} !== 3'b011) begin
      errors++;
      $display("FAIL frame_hold done/edges got %b %0d exp 0 3", frame_done, frame_edges);
    end
    px(16'd0, 1'b1);
    checks++;
    if ({frame_done, frame_edges} !== 3'b111) begin
      errors++;
      $display("FAIL frame_sat done/edges got %b %0d exp 1 3", frame_done, frame_edges);
    end
    idle();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_pulse_width done got %b exp 0", frame_done);
    end
  endtask

  task automatic test_reset_mid_line();
    hyst_en = 1'b1;
    for (int i = 0; i < 4; i++) px(16'd200, i == 0);
    px(16'd200, 1'b0);
    px(16'd200, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b1;
    gradient = 16'd200;
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, pixel_edge, pixel_strong, frame_edges, frame_done} !== 6'b0) begin
      errors++;
      $display("FAIL rst_mid outputs got %b%b%b %b %b exp all zero",
               out_valid, pixel_edge, pixel_strong, frame_edges, frame_done);
    end
    px(16'd200, 1'b0);
    px(16'd200, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_unarmed out_valid got %b exp 0", out_valid);
    end
    px(16'd60, 1'b1);
    checks++;
    if ({out_valid, pixel_edge, frame_done} !== 3'b100) begin
      errors++;
      $display("FAIL rst_first_sof valid/edge/done got %b%b%b exp 100",
               out_valid, pixel_edge, frame_done);
    end
    px(16'd60, 1'b0);
    checks++;
    if ({out_valid, pixel_edge} !== 2'b10) begin
      errors++;
      $display("FAIL rst_mask valid/edge got %b%b exp 10", out_valid, pixel_edge);
    end
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    sof       = 1'b0;
    gradient  = '0;
    thresh_hi = GRADIENT_THRESHOLD_HI;
    thresh_lo = GRADIENT_THRESHOLD_LO;
    hyst_en   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    test_pre_arm();
    test_single();
    test_hysteresis();
    test_gaps();
    test_masking();
    test_frame_count();
    test_reset_mid_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
